// File: rtl/div_pkg.sv
// div_pkg: shared constants and result record for the reciprocal divider collector
package div_pkg;
  localparam int M = 4;
  localparam int SERIES = 5;
  localparam int M_ACTIVE_MIN = 2;
  localparam int DIV_MIN = 2 ** (M_ACTIVE_MIN - 1);
  localparam logic [5:0] DIVIDEND = 6'b11_1111;
  typedef struct packed {
    logic              err;
    logic [SERIES-1:0] merchant;
    logic [M-1:0]      remainder;
  } div_result_t;
endpackage

// File: rtl/div_result_fifo.sv
// div_result_fifo: DEPTH-entry FIFO of div_result_t with registered head and occupancy count
module div_result_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  div_result_t   push_data,
  input  logic          ready,
  output logic          valid,
  output div_result_t   head,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  div_result_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop;
  assign valid = count != '0;
  assign pop = valid && ready;
  assign head = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/divider_result_collector.sv
// divider_result_collector: tracks divider issues, flags illegal divisors, buffers results with credit flow control
module divider_result_collector
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M-1:0]      in_divisor,
  input  logic [SERIES-1:0] div_merchant,
  input  logic [M-1:0]      div_remainder,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SERIES-1:0] out_merchant,
  output logic [M-1:0]      out_remainder,
  output logic              out_err,
  output logic [CW-1:0]     inflight
);
  logic [SERIES-1:0] vld_pipe, err_pipe;
  logic [CW-1:0] fifo_count;
  logic issue, capture, tail_err;
  div_result_t push_data, head;
  assign issue = in_valid && in_ready;
  assign capture = vld_pipe[SERIES-1];
  assign tail_err = err_pipe[SERIES-1];
  assign in_ready = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
  assign push_data = '{
    err: tail_err,
    merchant: tail_err ? '0 : div_merchant,
    remainder: tail_err ? '0 : div_remainder
  };
  assign out_err = head.err;
  assign out_merchant = head.merchant;
  assign out_remainder = head.remainder;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      inflight <= '0;
    end else begin
      vld_pipe <= {vld_pipe[SERIES-2:0], issue};
      err_pipe <= {err_pipe[SERIES-2:0], issue && (in_divisor < M'(DIV_MIN))};
      inflight <= inflight + CW'(issue) - CW'(capture);
    end
  end
  div_result_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(capture),
    .push_data(push_data),
    .ready(out_ready),
    .valid(out_valid),
    .head(head),
    .count(fifo_count)
  );
endmodule
